// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Function : Pipeline hazard unit: stall detection, D/E/M operand forwarding
//            selects and mult/div busy tracking for a 5-stage MIPS pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] a1_d,
  input  logic [4:0] a2_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] res_d,
  input  logic [1:0] tuse_rs,
  input  logic [1:0] tuse_rt,
  input  logic       md_d,
  input  logic       md_start_e,
  input  logic       md_op_e,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  localparam logic [1:0] c_res_alu   = 2'b01;
  localparam logic [1:0] c_res_dm    = 2'b10;
  localparam logic [1:0] c_tuse_none = 2'd3;
  localparam logic [1:0] c_fwd_rf    = 2'b00;
  localparam logic [1:0] c_fwd_e     = 2'b01;
  localparam logic [1:0] c_fwd_m     = 2'b10;
  localparam logic [1:0] c_fwd_w     = 2'b11;
  localparam logic [3:0] c_mult_cyc  = 4'(MULT_CYC);
  localparam logic [3:0] c_div_cyc   = 4'(DIV_CYC);

  logic [4:0] r_a1_e, r_a2_e, r_a3_e;
  logic [1:0] r_tnew_e;
  logic [4:0] r_a2_m, r_a3_m;
  logic [1:0] r_tnew_m;
  logic [4:0] r_a3_w;
  logic [1:0] r_tnew_w;
  logic [3:0] r_md_cnt;

  logic [1:0] w_tnew_d;
  logic [1:0] w_tnew_m_next;
  logic       w_haz_rs, w_haz_rt, w_haz_md;

  // A producer blocks a consumer only while its result is further away than the use.
  function automatic logic f_hazard(
    input logic [4:0] a,    input logic [1:0] tuse,
    input logic [4:0] a3e,  input logic [1:0] tne,
    input logic [4:0] a3m,  input logic [1:0] tnm
  );
    logic hit;
    hit = 1'b0;
    if (a != 5'd0 && tuse != c_tuse_none) begin
      if (a == a3e && tne > tuse) hit = 1'b1;
      if (a == a3m && tnm > tuse) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [1:0] f_fwd_d(
    input logic [4:0] a,
    input logic [4:0] a3e, input logic [1:0] tne,
    input logic [4:0] a3m, input logic [1:0] tnm,
    input logic [4:0] a3w, input logic [1:0] tnw
  );
    logic [1:0] sel;
    sel = c_fwd_rf;
    if (a != 5'd0) begin
      if (a == a3e && tne == 2'd0)      sel = c_fwd_e;
      else if (a == a3m && tnm == 2'd0) sel = c_fwd_m;
      else if (a == a3w && tnw == 2'd0) sel = c_fwd_w;
    end
    return sel;
  endfunction

  function automatic logic [1:0] f_fwd_e(
    input logic [4:0] a,
    input logic [4:0] a3m, input logic [1:0] tnm,
    input logic [4:0] a3w, input logic [1:0] tnw
  );
    logic [1:0] sel;
    sel = c_fwd_rf;
    if (a != 5'd0) begin
      if (a == a3m && tnm == 2'd0)      sel = c_fwd_m;
      else if (a == a3w && tnw == 2'd0) sel = c_fwd_w;
    end
    return sel;
  endfunction

  always_comb begin
    w_tnew_d = 2'd0;
    case (res_d)
      c_res_alu: w_tnew_d = 2'd1;
      c_res_dm:  w_tnew_d = 2'd2;
      default:   w_tnew_d = 2'd0;
    endcase
  end

  assign w_tnew_m_next = (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;

  always_comb begin
    w_haz_rs = f_hazard(a1_d, tuse_rs, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m);
    w_haz_rt = f_hazard(a2_d, tuse_rt, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m);
    w_haz_md = md_d && (md_busy || md_start_e);
    stall    = w_haz_rs || w_haz_rt || w_haz_md;
  end

  always_comb begin
    fwd_rs_d = f_fwd_d(a1_d, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    fwd_rt_d = f_fwd_d(a2_d, r_a3_e, r_tnew_e, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    fwd_rs_e = f_fwd_e(r_a1_e, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    fwd_rt_e = f_fwd_e(r_a2_e, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    fwd_rt_m = (r_a2_m != 5'd0) && (r_a2_m == r_a3_w);
  end

  // A stalled D instruction is replaced by a bubble in E; M and W always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a1_e   <= '0;
      r_a2_e   <= '0;
      r_a3_e   <= '0;
      r_tnew_e <= '0;
      r_a2_m   <= '0;
      r_a3_m   <= '0;
      r_tnew_m <= '0;
      r_a3_w   <= '0;
      r_tnew_w <= '0;
    end else begin
      if (stall) begin
        r_a1_e   <= '0;
        r_a2_e   <= '0;
        r_a3_e   <= '0;
        r_tnew_e <= '0;
      end else begin
        r_a1_e   <= a1_d;
        r_a2_e   <= a2_d;
        r_a3_e   <= a3_d;
        r_tnew_e <= w_tnew_d;
      end
      r_a2_m   <= r_a2_e;
      r_a3_m   <= r_a3_e;
      r_tnew_m <= w_tnew_m_next;
      r_a3_w   <= r_a3_m;
      r_tnew_w <= 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (md_start_e) begin
      r_md_cnt <= md_op_e ? c_div_cyc : c_mult_cyc;
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

  assign md_busy = (r_md_cnt != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Function : Self-checking bench for hazard_ctrl: directed pipeline scenarios
//            and random traffic scored against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] a1_d, a2_d, a3_d;
  logic [1:0] res_d, tuse_rs, tuse_rt;
  logic       md_d, md_start_e, md_op_e;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) u_dut (
    .clk(clk), .reset(reset),
    .a1_d(a1_d), .a2_d(a2_d), .a3_d(a3_d), .res_d(res_d),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .md_d(md_d), .md_start_e(md_start_e), .md_op_e(md_op_e),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a1, a2, a3;
    logic [1:0] res, trs, trt;
    logic       md, ms, mop;
  } din_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] frsd, frtd, frse, frte;
    logic       frtm, busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference pipeline state, advanced once per clock edge.
  logic [4:0] me_a1, me_a2, me_a3, mm_a2, mm_a3, mw_a3;
  logic [1:0] me_tn, mm_tn;
  int         m_cnt;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic din_t mk(int a1, int a2, int a3, int res, int trs, int trt,
                              int md = 0, int ms = 0, int mop = 0);
    din_t d;
    d.a1 = 5'(a1); d.a2 = 5'(a2); d.a3 = 5'(a3); d.res = 2'(res);
    d.trs = 2'(trs); d.trt = 2'(trt);
    d.md = 1'(md); d.ms = 1'(ms); d.mop = 1'(mop);
    return d;
  endfunction

  function automatic logic haz(logic [4:0] a, logic [1:0] tuse);
    if (a == 0 || tuse == 3) return 1'b0;
    return (a == me_a3 && me_tn > tuse) || (a == mm_a3 && mm_tn > tuse);
  endfunction

  function automatic logic [1:0] src_d(logic [4:0] a);
    if (a == 0) return 2'b00;
    if (a == me_a3 && me_tn == 0) return 2'b01;
    if (a == mm_a3 && mm_tn == 0) return 2'b10;
    if (a == mw_a3) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] src_e(logic [4:0] a);
    if (a == 0) return 2'b00;
    if (a == mm_a3 && mm_tn == 0) return 2'b10;
    if (a == mw_a3) return 2'b11;
    return 2'b00;
  endfunction

  function automatic exp_t model_out(din_t d);
    exp_t e;
    e.busy  = (m_cnt != 0);
    e.stall = haz(d.a1, d.trs) || haz(d.a2, d.trt) || (d.md && (e.busy || d.ms));
    e.frsd  = src_d(d.a1);
    e.frtd  = src_d(d.a2);
    e.frse  = src_e(me_a1);
    e.frte  = src_e(me_a2);
    e.frtm  = (mm_a2 != 0) && (mm_a2 == mw_a3);
    return e;
  endfunction

  task automatic model_reset();
    me_a1 = 0; me_a2 = 0; me_a3 = 0; me_tn = 0;
    mm_a2 = 0; mm_a3 = 0; mm_tn = 0; mw_a3 = 0; m_cnt = 0;
  endtask

  task automatic model_adv(din_t d, logic stl);
    mw_a3 = mm_a3;
    mm_a2 = me_a2;
    mm_a3 = me_a3;
    mm_tn = (me_tn > 0) ? me_tn - 2'd1 : 2'd0;
    if (stl) begin
      me_a1 = 0; me_a2 = 0; me_a3 = 0; me_tn = 0;
    end else begin
      me_a1 = d.a1; me_a2 = d.a2; me_a3 = d.a3;
      me_tn = (d.res == 2'b01) ? 2'd1 : (d.res == 2'b10) ? 2'd2 : 2'd0;
    end
    if (d.ms) m_cnt = d.mop ? 10 : 5;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
  endtask

  task automatic apply(din_t d);
    a1_d = d.a1; a2_d = d.a2; a3_d = d.a3; res_d = d.res;
    tuse_rs = d.trs; tuse_rt = d.trt;
    md_d = d.md; md_start_e = d.ms; md_op_e = d.mop;
  endtask

  task automatic score(string pfx);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s scoreboard empty", pfx);
      return;
    end
    e = sb.pop_front();
    chk({pfx, ".stall"},    8'(stall),    8'(e.stall));
    chk({pfx, ".fwd_rs_d"}, 8'(fwd_rs_d), 8'(e.frsd));
    chk({pfx, ".fwd_rt_d"}, 8'(fwd_rt_d), 8'(e.frtd));
    chk({pfx, ".fwd_rs_e"}, 8'(fwd_rs_e), 8'(e.frse));
    chk({pfx, ".fwd_rt_e"}, 8'(fwd_rt_e), 8'(e.frte));
    chk({pfx, ".fwd_rt_m"}, 8'(fwd_rt_m), 8'(e.frtm));
    chk({pfx, ".md_busy"},  8'(md_busy),  8'(e.busy));
  endtask

  // One pipeline cycle: drive after the edge, score mid-cycle, then step the model.
  task automatic cyc(din_t d, string pfx);
    exp_t e;
    @(posedge clk);
    #1;
    apply(d);
    e = model_out(d);
    sb.push_back(e);
    #3;
    score(pfx);
    model_adv(d, e.stall);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) cyc(mk(0, 0, 0, 0, 3, 3), "flush");
  endtask

  din_t nop, lw8, addu98, mflo;

  initial begin
    nop = mk(0, 0, 0, 0, 3, 3);
    model_reset();
    reset = 1'b0;
    apply(nop);
    #12;
    sb.push_back(model_out(nop));
    score("reset");
    chk("reset.stall", 8'(stall), 8'd0);
    #10 reset = 1'b1;

    // lw $8 followed by addu $9,$8,$8
    lw8    = mk(29, 8, 8, 2, 1, 3);
    addu98 = mk(8, 8, 9, 1, 1, 1);
    cyc(lw8, "lw");
    chk("lw.stall", 8'(stall), 8'd0);
    cyc(addu98, "use1");
    chk("use1.stall", 8'(stall), 8'd1);
    cyc(addu98, "use2");
    chk("use2.stall", 8'(stall), 8'd0);
    cyc(nop, "use3");
    chk("use3.fwd_rs_e", 8'(fwd_rs_e), 8'd3);
    chk("use3.fwd_rt_e", 8'(fwd_rt_e), 8'd3);

    // addu $3 then beq $3,$0
    flush();
    cyc(mk(1, 2, 3, 1, 1, 1), "addu3");
    cyc(mk(3, 0, 0, 0, 0, 0), "beq1");
    chk("beq1.stall", 8'(stall), 8'd1);
    cyc(mk(3, 0, 0, 0, 0, 0), "beq2");
    chk("beq2.stall", 8'(stall), 8'd0);
    chk("beq2.fwd_rs_d", 8'(fwd_rs_d), 8'd2);

    // jal then jr $31
    flush();
    cyc(mk(0, 0, 31, 3, 3, 3), "jal");
    cyc(mk(31, 0, 0, 0, 0, 3), "jr");
    chk("jr.stall", 8'(stall), 8'd0);
    chk("jr.fwd_rs_d", 8'(fwd_rs_d), 8'd1);

    // load to $0 never creates a dependency
    flush();
    cyc(mk(29, 0, 0, 2, 1, 3), "lw0");
    cyc(mk(0, 0, 4, 1, 0, 3), "use0");
    chk("use0.stall", 8'(stall), 8'd0);
    chk("use0.fwd_rs_d", 8'(fwd_rs_d), 8'd0);

    // div start with mflo waiting in D
    flush();
    mflo = mk(0, 0, 5, 1, 3, 3, 1);
    cyc(mk(0, 0, 5, 1, 3, 3, 1, 1, 1), "div0");
    chk("div0.stall", 8'(stall), 8'd1);
    chk("div0.md_busy", 8'(md_busy), 8'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(mflo, "divw");
      chk("divw.stall", 8'(stall), 8'd1);
      chk("divw.md_busy", 8'(md_busy), 8'd1);
    end
    cyc(mflo, "divdone");
    chk("divdone.stall", 8'(stall), 8'd0);
    chk("divdone.md_busy", 8'(md_busy), 8'd0);

    // async reset with counter at 7 and lw $8 in E
    flush();
    cyc(mk(0, 0, 0, 0, 3, 3, 0, 1, 1), "rdiv");
    cyc(nop, "rnop");
    cyc(nop, "rnop");
    cyc(lw8, "rlw");
    cyc(mk(8, 8, 9, 1, 0, 0, 1), "rpre");
    chk("rpre.stall", 8'(stall), 8'd1);
    chk("rpre.md_busy", 8'(md_busy), 8'd1);
    reset = 1'b0;
    #1;
    model_reset();
    sb.push_back(model_out(mk(8, 8, 9, 1, 0, 0, 1)));
    score("arst");
    chk("arst.stall", 8'(stall), 8'd0);
    chk("arst.md_busy", 8'(md_busy), 8'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    cyc(nop, "post_rst");
    chk("post_rst.md_busy", 8'(md_busy), 8'd0);

    // random traffic on a small register set to provoke matches
    for (int i = 0; i < 400; i++) begin
      din_t d;
      d.a1  = 5'($urandom_range(0, 3));
      d.a2  = 5'($urandom_range(0, 3));
      d.a3  = 5'($urandom_range(0, 3));
      d.res = 2'($urandom_range(0, 3));
      d.trs = 2'($urandom_range(0, 3));
      d.trt = 2'($urandom_range(0, 3));
      d.md  = ($urandom_range(0, 3) == 0);
      d.ms  = ($urandom_range(0, 7) == 0);
      d.mop = 1'($urandom_range(0, 1));
      cyc(d, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
